// File: rtl/riscv_pkg.sv
// Shared decode constants and FSM encodings for the multiply/divide unit.
// Opcode values match the control decoder's alu_opcode field.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;

  localparam logic [4:0] ALU_MUL    = 5'b01001;
  localparam logic [4:0] ALU_MULH   = 5'b01010;
  localparam logic [4:0] ALU_MULHU  = 5'b01011;
  localparam logic [4:0] ALU_MULHSU = 5'b01100;
  localparam logic [4:0] ALU_DIV    = 5'b01101;
  localparam logic [4:0] ALU_DIVU   = 5'b01110;
  localparam logic [4:0] ALU_REM    = 5'b01111;
  localparam logic [4:0] ALU_REMU   = 5'b10000;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic is_mulh_op(input logic [4:0] op);
    return (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
  endfunction

  // rs1 is treated as signed by these ops; rs2 only by MULH/DIV/REM.
  function automatic logic a_signed_op(input logic [4:0] op);
    return (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic b_signed_op(input logic [4:0] op);
    return (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
  endfunction

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negate with sign flag: with negate tied to the
// sign bit it is an absolute value, otherwise a plain sign-correcting negate.
module muldiv_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] mag,
  output logic         sign
);

  assign sign = value[W-1];
  assign mag  = negate ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative radix-2 multiply/divide unit: IDLE -> CALC (XLEN steps) -> FIX -> DONE.
// Define MULDIV_FAST_MUL_EN to route multiplies through a single-cycle multiplier.
module alu_muldiv_seq
  import riscv_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [4:0]      alu_opcode,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [4:0]          op_q;
  logic                div_q, neg_q, rem_neg_q, spec_q;
  logic [XLEN-1:0]     opd_q, spec_res_q;
  logic [2*XLEN-1:0]   acc;

  logic                idle, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]     abs0_in, abs1_in, abs0_mag, abs1_mag, spec_res;
  logic                abs0_neg, abs1_neg, abs0_sign, abs1_sign;
  logic [XLEN-1:0]     acc_hi, acc_lo, hi_neg, fix_res;
  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0]   mul_next, div_next;

  assign idle   = (state == ST_IDLE);
  assign acc_hi = acc[2*XLEN-1:XLEN];
  assign acc_lo = acc[XLEN-1:0];

  // The two abs units take the raw operands at capture and the result words in FIX.
  assign a_neg    = a_signed_op(alu_opcode) & abs0_sign;
  assign b_neg    = b_signed_op(alu_opcode) & abs1_sign;
  assign abs0_in  = idle ? op_a : acc_lo;
  assign abs1_in  = idle ? op_b : acc_hi;
  assign abs0_neg = idle ? a_neg : neg_q;
  assign abs1_neg = idle ? b_neg : rem_neg_q;

  muldiv_abs #(.W(XLEN)) u_abs_a (
    .value (abs0_in),
    .negate(abs0_neg),
    .mag   (abs0_mag),
    .sign  (abs0_sign)
  );

  muldiv_abs #(.W(XLEN)) u_abs_b (
    .value (abs1_in),
    .negate(abs1_neg),
    .mag   (abs1_mag),
    .sign  (abs1_sign)
  );

  assign div_zero = (op_b == '0);
  assign div_ovf  = b_signed_op(alu_opcode) && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  assign spec_res = is_rem_op(alu_opcode) ? (div_zero ? op_a : '0)
                                          : (div_zero ? DIV_ZERO_Q : {1'b1, {(XLEN-1){1'b0}}});

  // Multiply: acc = {partial, multiplier}; add multiplicand when lsb set, shift right.
  assign mul_sum  = {1'b0, acc_hi} + ({1'b0, opd_q} & {(XLEN+1){acc[0]}});
  assign mul_next = {mul_sum, acc_lo[XLEN-1:1]};

  // Divide: acc = {remainder, dividend->quotient}; restoring shift-subtract.
  assign div_shift = {acc_hi, acc_lo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opd_q};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_lo[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1};

  // High word of the negated 64-bit product: borrow only propagates when low word is 0.
  assign hi_neg = ~acc_hi + {{(XLEN-1){1'b0}}, (acc_lo == '0)};

  always_comb begin
    fix_res = abs0_mag;
    if (spec_q)                fix_res = spec_res_q;
    else if (is_mulh_op(op_q)) fix_res = neg_q ? hi_neg : acc_hi;
    else if (is_rem_op(op_q))  fix_res = abs1_mag;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [XLEN:0]     fast_a, fast_b;
  logic [2*XLEN-1:0] fast_prod;
  assign fast_a    = {a_signed_op(alu_opcode) & op_a[XLEN-1], op_a};
  assign fast_b    = {b_signed_op(alu_opcode) & op_b[XLEN-1], op_b};
  assign fast_prod = {{(XLEN-1){fast_a[XLEN]}}, fast_a} * {{(XLEN-1){fast_b[XLEN]}}, fast_b};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      result     <= '0;
      op_q       <= '0;
      div_q      <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      opd_q      <= '0;
      acc        <= '0;
    end else if (flush && !idle) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !flush && is_muldiv(alu_opcode)) begin
            op_q       <= alu_opcode;
            div_q      <= is_div_op(alu_opcode);
            neg_q      <= a_neg ^ b_neg;
            rem_neg_q  <= a_neg;
            cnt        <= '0;
            spec_res_q <= spec_res;
            if (is_div_op(alu_opcode)) begin
              opd_q  <= abs1_mag;
              acc    <= {{XLEN{1'b0}}, abs0_mag};
              spec_q <= div_zero | div_ovf;
              state  <= (div_zero | div_ovf) ? ST_FIX : ST_CALC;
            end else begin
              opd_q  <= abs0_mag;
              acc    <= {{XLEN{1'b0}}, abs1_mag};
              spec_q <= 1'b0;
              state  <= ST_CALC;
`ifdef MULDIV_FAST_MUL_EN
              acc    <= fast_prod;
              neg_q  <= 1'b0;
              state  <= ST_FIX;
`endif
            end
          end
        end
        ST_CALC: begin
          acc <= div_q ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          result <= fix_res;
          state  <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_CALC) || (state == ST_FIX);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed and randomized checks of alu_muldiv_seq against a plain-arithmetic model.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [4:0]  opcode;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  alu_muldiv_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .flush     (flush),
    .alu_opcode(opcode),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_div(input logic [4:0] op);
    return op inside {5'b01101, 5'b01110, 5'b01111, 5'b10000};
  endfunction

  // Reference model: the architectural definition of each op in wide arithmetic.
  function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a, b);
    longint      sa, sb, ub, sp;
    logic [63:0] up;
    int          ia, ib;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = {32'h0, b};
    up  = {32'h0, a} * {32'h0, b};
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      5'b01001: return up[31:0];
      5'b01010: begin sp = sa * sb; return sp[63:32]; end
      5'b01100: begin sp = sa * ub; return sp[63:32]; end
      5'b01011: return up[63:32];
      5'b01101: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(ia / ib));
      5'b01110: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'b01111: return (b == 0) ? a : (ovf ? 32'h0 : 32'(ia % ib));
      5'b10000: return (b == 0) ? a : a % b;
      default:  return 32'h0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a, b);
    if (is_div(op) && ((b == 0) || ((op inside {5'b01101, 5'b01111}) &&
        (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))))
      return 2;
`ifdef MULDIV_FAST_MUL_EN
    if (!is_div(op)) return 2;
`endif
    return 34;
  endfunction

  // Issue one op, scramble operands after capture, wait (bounded) for done.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    start = 1'b1; opcode = op; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom; opcode = 5'($urandom);
    lat = 1;
    check("busy_after_start", {31'b0, busy}, 32'd1);
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check("busy_low_in_done", {31'b0, busy}, 32'd0);
    res = result;
    @(posedge clk); #1;
    check("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  task automatic run_check(input string tag, input logic [4:0] op, input logic [31:0] a, b,
                           input logic [31:0] exp);
    logic [31:0] res;
    int          lat;
    run_op(op, a, b, res, lat);
    check({tag, "_result"}, res, exp);
    check({tag, "_latency"}, 32'(lat), 32'(ref_latency(op, a, b)));
  endtask

  initial begin
    vec_t        dir_q[$];
    logic [4:0]  ops[8];
    logic [31:0] prev, a, b;
    logic [4:0]  op;
    int          seen;

    rst = 1'b1; start = 1'b0; flush = 1'b0; opcode = '0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;

    dir_q.push_back('{"mul",      5'b01001, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB});
    dir_q.push_back('{"mulh",     5'b01010, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF});
    dir_q.push_back('{"mulhu",    5'b01011, 32'd7,         32'hFFFF_FFFD, 32'h0000_0006});
    dir_q.push_back('{"div",      5'b01101, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD});
    dir_q.push_back('{"rem",      5'b01111, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF});
    dir_q.push_back('{"divu",     5'b01110, 32'd100,       32'd7,         32'd14});
    dir_q.push_back('{"remu",     5'b10000, 32'd100,       32'd7,         32'd2});
    dir_q.push_back('{"div_zero", 5'b01101, 32'h1234,      32'd0,         32'hFFFF_FFFF});
    dir_q.push_back('{"rem_zero", 5'b01111, 32'h1234,      32'd0,         32'h1234});
    dir_q.push_back('{"divu_zero",5'b01110, 32'h1234,      32'd0,         32'hFFFF_FFFF});
    dir_q.push_back('{"div_ovf",  5'b01101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    dir_q.push_back('{"rem_ovf",  5'b01111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0});
    dir_q.push_back('{"mulhsu",   5'b01100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    foreach (dir_q[i])
      run_check(dir_q[i].tag, dir_q[i].op, dir_q[i].a, dir_q[i].b, dir_q[i].exp);

    // Flush in cycle 10 of a MULHSU.
    prev = result;
    @(negedge clk);
    start = 1'b1; opcode = 5'b01100; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_result_held", result, prev);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) seen++; end
    check("flush_no_done", 32'(seen), 32'd0);
    check("flush_result_still_held", result, prev);
    run_check("divu_after_flush", 5'b01110, 32'd9, 32'd3, 32'd3);

    // Reset in cycle 20 of a DIV.
    @(negedge clk);
    start = 1'b1; opcode = 5'b01101; op_a = 32'd1000; op_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_result", result, 32'd0);

    // Non-muldiv opcode is ignored.
    @(negedge clk);
    start = 1'b1; opcode = 5'b00000; op_a = 32'd5; op_b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) seen++; end
    check("bad_opcode_ignored", 32'(seen), 32'd0);
    check("bad_opcode_result", result, 32'd0);

    ops = '{5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b10000};
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 7)];
      a  = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_check("rand", op, a, b, ref_model(op, a, b));
    end

`ifdef MULDIV_FAST_MUL_EN
    run_check("fast_mul", 5'b01001, 32'h0001_0000, 32'h0001_0000, 32'h0);
    run_check("fast_mulhu", 5'b01011, 32'h0001_0000, 32'h0001_0000, 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
